// File: rtl/alu_accumulator.sv
// alu_accumulator: registered W-bit ALU whose B operand is the low half of its own 2W-bit result.
// Define ALU_MULT_EN to build in the multi-cycle shift-add multiply (Function=010) and its Busy handshake.
module alu_accumulator #(
    parameter int W = 4
) (
    input  logic             Clock,
    input  logic             Reset_b,
    input  logic [W-1:0]     Data,
    input  logic [2:0]       Function,
    input  logic             Start,
    output logic             Busy,
    output logic             Done,
    output logic [2*W-1:0]   ALUout
);
    localparam int PW = 2 * W;
    logic [W-1:0]  a, b;
    logic [W:0]    usum, ssum;
    logic [PW-1:0] op_result, mul_result;
    logic          launch, is_mul, mul_done, single;
    assign a      = Data;
    assign b      = ALUout[W-1:0];
    assign usum   = {1'b0, a} + {1'b0, b};
    assign ssum   = {a[W-1], a} + {b[W-1], b};
    assign launch = Start && !Busy;
    assign single = launch && !is_mul;
    // 010 falls into the hold default: it only reaches here as a hold when the multiplier is absent
    always_comb begin
        op_result = ALUout;
        case (Function)
            3'b000:  op_result = {{(W-1){1'b0}}, usum};
            3'b001:  op_result = {{(W-1){ssum[W]}}, ssum};
            3'b011:  op_result = {{(PW-1){1'b0}}, |{a, b}};
            3'b100:  op_result = {{(PW-1){1'b0}}, |(a & b)};
            3'b101:  op_result = {a, b};
            3'b110:  op_result = {{W{1'b0}}, b} << a;
            default: op_result = ALUout;
        endcase
    end
`ifdef ALU_MULT_EN
    localparam int CW = $clog2(W);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MULT = 1'b1;
    logic [0:0]    state;
    logic [PW-1:0] mcand, pp, pp_next;
    logic [W-1:0]  mplier;
    logic [CW-1:0] cnt;
    assign is_mul     = Function == 3'b010;
    assign Busy       = state == MULT;
    assign pp_next    = pp + (mplier[0] ? mcand : '0);
    assign mul_done   = (state == MULT) && (cnt == CW'(W - 1));
    assign mul_result = pp_next;
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            pp     <= '0;
            cnt    <= '0;
        end else if (state == IDLE) begin
            if (launch && is_mul) begin
                state  <= MULT;
                mcand  <= {{W{1'b0}}, a};
                mplier <= b;
                pp     <= '0;
                cnt    <= '0;
            end
        end else begin
            pp     <= pp_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_done)
                state <= IDLE;
        end
    end
`else
    assign is_mul     = 1'b0;
    assign Busy       = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
`endif
    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            ALUout <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= single || mul_done;
            if (mul_done)
                ALUout <= mul_result;
            else if (single)
                ALUout <= op_result;
        end
    end
endmodule

// File: tb/tb_alu_accumulator.sv
// tb_alu_accumulator: directed-vector bench for alu_accumulator at W=4.
module tb_alu_accumulator;
    logic       clk = 1'b0;
    logic       reset_b = 1'b0;
    logic [3:0] data = '0;
    logic [2:0] func = '0;
    logic       start = 1'b0;
    logic       busy, done;
    logic [7:0] alu_out;
    int n_chk = 0;
    int n_err = 0;

    alu_accumulator #(.W(4)) dut (
        .Clock(clk), .Reset_b(reset_b), .Data(data), .Function(func),
        .Start(start), .Busy(busy), .Done(done), .ALUout(alu_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a one-edge launch; returns 1 time unit after the launching edge.
    task automatic issue(input logic [2:0] f, input logic [3:0] d);
        start = 1'b1;
        func  = f;
        data  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        reset_b = 1'b0;
        #2;
        reset_b = 1'b1;
    endtask

    task automatic op_check(input string tag, input logic [2:0] f, input logic [3:0] d, input logic [7:0] exp);
        issue(f, d);
        check({tag, "_out"}, alu_out, exp);
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    endtask

    initial begin
        #1;
        check("rst_out", alu_out, 8'h00);
        check("rst_done", {7'd0, done}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_out", alu_out, 8'h00);
        start = 1'b0;
        #2;
        reset_b = 1'b1;

        op_check("acc1", 3'b000, 4'h5, 8'h05);
        op_check("acc2", 3'b000, 4'hC, 8'h11);
        @(posedge clk);
        #1;
        check("acc_done_low", {7'd0, done}, 8'd0);
        check("acc_keep", alu_out, 8'h11);

        #2;
        reset_b = 1'b0;
        #1;
        check("async_rst_out", alu_out, 8'h00);
        check("async_rst_done", {7'd0, done}, 8'd0);
        start = 1'b1;
        func  = 3'b000;
        data  = 4'h5;
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_out", alu_out, 8'h00);
        check("rst_held_done", {7'd0, done}, 8'd0);
        start = 1'b0;
        #2;
        reset_b = 1'b1;

        op_check("sadd_load", 3'b000, 4'hE, 8'h0E);
        op_check("sadd", 3'b001, 4'hD, 8'hFB);

        do_reset();
        op_check("shl_load", 3'b000, 4'h3, 8'h03);
        op_check("shl4", 3'b110, 4'h4, 8'h30);
        do_reset();
        op_check("shl_reload", 3'b000, 4'h3, 8'h03);
        op_check("shl9", 3'b110, 4'h9, 8'h00);

        do_reset();
        op_check("log_load", 3'b000, 4'h6, 8'h06);
        op_check("and_zero", 3'b100, 4'h9, 8'h00);
        op_check("or_zero", 3'b011, 4'h0, 8'h00);
        op_check("or_one", 3'b011, 4'h2, 8'h01);
        op_check("and_one", 3'b100, 4'h1, 8'h01);
        op_check("concat", 3'b101, 4'hA, 8'hA1);
        op_check("hold", 3'b111, 4'hF, 8'hA1);
        op_check("after_hold", 3'b000, 4'h7, 8'h08);

`ifdef ALU_MULT_EN
        do_reset();
        op_check("mul_load", 3'b000, 4'hB, 8'h0B);
        issue(3'b010, 4'hD);
        check("mul_busy0", {7'd0, busy}, 8'd1);
        check("mul_done0", {7'd0, done}, 8'd0);
        check("mul_out0", alu_out, 8'h0B);
        for (int i = 1; i <= 4; i++) begin
            if (i == 2) begin
                start = 1'b1;
                func  = 3'b000;
                data  = 4'h1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("mul_busy%0d", i), {7'd0, busy}, i < 4 ? 8'd1 : 8'd0);
            check($sformatf("mul_done%0d", i), {7'd0, done}, i < 4 ? 8'd0 : 8'd1);
            check($sformatf("mul_out%0d", i), alu_out, i < 4 ? 8'h0B : 8'h8F);
        end
        @(posedge clk);
        #1;
        check("mul_after_done", {7'd0, done}, 8'd0);
        check("mul_after_out", alu_out, 8'h8F);

        do_reset();
        op_check("abort_load", 3'b000, 4'h3, 8'h03);
        issue(3'b010, 4'h5);
        @(posedge clk);
        #2;
        reset_b = 1'b0;
        #1;
        check("abort_out", alu_out, 8'h00);
        check("abort_busy", {7'd0, busy}, 8'd0);
        check("abort_done", {7'd0, done}, 8'd0);
        #2;
        reset_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort_quiet_done%0d", i), {7'd0, done}, 8'd0);
            check($sformatf("abort_quiet_out%0d", i), alu_out, 8'h00);
        end
`else
        do_reset();
        op_check("nomul_load", 3'b000, 4'h9, 8'h09);
        op_check("nomul_hold", 3'b010, 4'h3, 8'h09);
        @(posedge clk);
        #1;
        check("nomul_done_low", {7'd0, done}, 8'd0);
        check("nomul_busy_low", {7'd0, busy}, 8'd0);
        check("nomul_keep", alu_out, 8'h09);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_accumulator.md
# alu_accumulator

Parametrised, registered successor to the 4-bit combinational ALU. It performs a W-bit operation between an input operand and the low half of its own 2W-bit result register. Operations are launched by a Start pulse and retire with a one-cycle Done pulse. An optional multi-cycle shift-add multiply runs under a Busy handshake. The block sits between the switch/operand inputs and the hex-display or datapath consumer, replacing the combinational ALU plus external result register.

## Interface
- `W`, default 4: operand width, must be ≥ 2. The result register is 2W bits wide.
- `Clock`  in  1  rising-edge clock for all state.
- `Reset_b`  in  1  asynchronous, active-low reset.
- `Data`  in  W  operand A, sampled on the launching edge.
- `Function`  in  3  operation select, sampled on the launching edge.
- `Start`  in  1  launch request, level-sampled each rising edge.
- `Busy`  out  1  high while a multi-cycle operation is in progress.
- `Done`  out  1  one-cycle pulse marking the cycle in which a new result first appears on `ALUout`.
- `ALUout`  out  2W  result register. Operand B is always `ALUout[W-1:0]`.

## Operation
- **Launch:** on a rising edge with `Start`=1 and `Busy`=0. `Start` while `Busy`=1 is ignored (no queuing).
- **Function codes** (A = `Data`, B = `ALUout[W-1:0]`):
  - 000: unsigned A+B. The W+1-bit sum is zero-extended to 2W.
  - 001: signed A+B. The W+1-bit two's-complement sum is sign-extended to 2W.
  - 010: unsigned A*B, multi-cycle (only with `ALU_MULT_EN`).
  - 011: `ALUout` = 1 if {A,B} ≠ 0, else 0.
  - 100: `ALUout` = 1 if (A & B) ≠ 0, else 0.
  - 101: `ALUout` = {A, B}.
  - 110: `ALUout` = ({W zeros, B} << A), truncated to 2W bits. A ≥ 2W gives 0.
  - 111: hold. `ALUout` unchanged, `Done` still pulses.
- **FSM states:** IDLE and MULT.
  - IDLE → MULT on a launch with Function=010.
  - MULT → IDLE after W iterations.
- **Multiply datapath:**
  - A and B are latched into internal registers on the launch edge.
  - Each MULT cycle examines one multiplier bit, LSB first. If the bit is set, the shifted multiplicand is added into a 2W-bit partial product.
  - `ALUout` is not modified until the final iteration.
- **Reset:** `ALUout`=0, `Busy`=0, `Done`=0, state IDLE. A reset asserted during MULT aborts the multiply with no partial writeback.

## Timing
- **Single-cycle ops:** launch at edge N → `ALUout` updated at edge N. `Done`=1 for cycle N→N+1. `Busy` stays 0.
- **Multiply:**
  - Launch at edge N → `Busy`=1 from edge N.
  - Iterations occur on edges N+1..N+W.
  - The final product is written to `ALUout` at edge N+W. At that same edge `Busy` falls and `Done` rises for one cycle.
- **Back-to-back:** a new launch is legal on the edge where `Done` is high (i.e. the edge after the result edge). Single-cycle ops can therefore issue every cycle. B for each op is the previous result.
- `Done` is never high on two consecutive cycles unless two launches occurred on consecutive edges.
- **Reset timing:** `Reset_b` low forces all outputs to their reset values asynchronously. Release is synchronous to the next rising edge.

## Configuration
- **`ALU_MULT_EN` defined:** the MULT state, operand latches, partial-product register and Function=010 multiply are compiled in.
- **`ALU_MULT_EN` undefined:** Function=010 behaves exactly as 111 (hold, single-cycle `Done`), `Busy` is tied to 0, and no multiply logic is synthesised.

## Test plan
All scenarios use W=4.
1. **Reset:** assert `Reset_b`=0 mid-cycle → `ALUout`=8'h00, `Busy`=0, `Done`=0 immediately; no change on the following edges while held.
2. **Accumulate:** from reset, Start with 000, `Data`=4'h5 → `ALUout`=8'h05 and `Done` pulses; next cycle Start with 000, `Data`=4'hC → `ALUout`=8'h11.
3. **Signed add:** from reset, Start with 000, `Data`=4'hE → 8'h0E; then Start with 001, `Data`=4'hD (−2 + −3) → `ALUout`=8'hFB.
4. **Multiply** (`ALU_MULT_EN` defined): load B=4'hB, then Start with 010, `Data`=4'hD → `Busy` high for exactly 4 cycles, `ALUout` stays 8'h0B until the final edge, then 8'h8F with `Done`. A Start pulsed mid-multiply has no effect.
5. **Shift:** load B=4'h3, then Start with 110, `Data`=4'h4 → 8'h30; reload B=4'h3, then Start with 110, `Data`=4'h9 → 8'h00.
6. **Abort/disabled:** reset during cycle 2 of a multiply → `ALUout`=8'h00, `Busy`=0, no `Done`. With `ALU_MULT_EN` undefined, Function=010 leaves `ALUout` unchanged, `Done` pulses once and `Busy` stays 0.
